// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int SSUB_STATE_W = 2;

  typedef enum logic [SSUB_STATE_W-1:0] {
    SSUB_IDLE = 2'd0,
    SSUB_RUN  = 2'd1,
    SSUB_DONE = 2'd2
  } ssub_state_e;

  // Bit counter width; clamped to 1 so a degenerate WIDTH still elaborates.
  function automatic int ssub_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_subtractor1bit.sv
// One-bit full subtractor slice: the borrow-chain counterpart of adder1bit.
module subtractor1bit (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = in_a - in_b, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero
);

  localparam int CNT_W = ssub_cnt_w(WIDTH);

  ssub_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             br_reg, nz_reg;
  logic             slice_d, slice_bo;
  logic             accept, running, last_bit;

  assign accept   = (state_reg == SSUB_IDLE) && in_valid;
  assign running  = (state_reg == SSUB_RUN);
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  subtractor1bit u_slice (
    .diff (slice_d),
    .bout (slice_bo),
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (br_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= SSUB_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SSUB_IDLE: if (in_valid)  state_next = SSUB_RUN;
      SSUB_RUN:  if (last_bit)  state_next = SSUB_DONE;
      SSUB_DONE: if (out_ready) state_next = SSUB_IDLE;
      default:                  state_next = SSUB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt_reg <= '0;
    else if (accept)  cnt_reg <= '0;
    else if (running) cnt_reg <= cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
    end else if (running) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
    end
  end

  // Difference bits enter at the MSB so that after WIDTH shifts bit k sits at res_reg[k].
  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg <= '0;
      br_reg  <= 1'b0;
      nz_reg  <= 1'b0;
    end else if (accept) begin
      res_reg <= '0;
      br_reg  <= 1'b0;
      nz_reg  <= 1'b0;
    end else if (running) begin
      res_reg <= {slice_d, res_reg[WIDTH-1:1]};
      br_reg  <= slice_bo;
      nz_reg  <= nz_reg | slice_d;
    end
  end

  assign in_ready   = (state_reg == SSUB_IDLE);
  assign out_valid  = (state_reg == SSUB_DONE);
  assign out_diff   = res_reg;
  assign out_borrow = br_reg;
  // Gated so the flag reads 0 out of reset rather than reflecting the cleared accumulator.
  assign out_zero   = (state_reg == SSUB_DONE) & ~nz_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 3, 32 and 8 against a cycle-level transaction model.
module tb_serial_subtractor;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [NI];
  logic        out_ready [NI];
  logic [63:0] in_a      [NI];
  logic [63:0] in_b      [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        out_borrow[NI];
  logic        out_zero  [NI];
  logic [63:0] out_diff  [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit          m_pending [NI];
  int          m_age     [NI];
  logic [63:0] m_diff    [NI];
  bit          m_borrow  [NI];
  bit          m_zero    [NI];
  int          m_results [NI];
  int          dut_results[NI];
  int          dut_acc   [NI];
  int          last_acc  [NI];
  bit          rand_done = 1'b0;

  always #5 clk = ~clk;

  function automatic int wid(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 32 : 8);
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_diff(input logic [63:0] a, input logic [63:0] b, input int w);
    return (a - b) & wmask(w);
  endfunction

  function automatic bit ref_borrow(input logic [63:0] a, input logic [63:0] b, input int w);
    return (a & wmask(w)) < (b & wmask(w));
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 3 : ((gi == 1) ? 32 : 8);
    logic [W-1:0] diff_w;
    serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .in_a       (in_a[gi][W-1:0]),
      .in_b       (in_b[gi][W-1:0]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .out_diff   (diff_w),
      .out_borrow (out_borrow[gi]),
      .out_zero   (out_zero[gi])
    );
    assign out_diff[gi] = 64'(diff_w);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model + compare: checks outputs each cycle, then advances the model for the coming edge.
  initial begin
    for (int i = 0; i < NI; i++) begin
      m_pending[i] = 0; m_age[i] = 0; m_results[i] = 0;
      dut_results[i] = 0; dut_acc[i] = 0; last_acc[i] = -1;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        bit exp_valid;
        exp_valid = m_pending[i] && (m_age[i] >= wid(i));
        chk($sformatf("w%0d in_ready", wid(i)), 64'(in_ready[i]), 64'(!m_pending[i]));
        chk($sformatf("w%0d out_valid", wid(i)), 64'(out_valid[i]), 64'(exp_valid));
        if (exp_valid) begin
          chk($sformatf("w%0d out_diff", wid(i)), out_diff[i], m_diff[i]);
          chk($sformatf("w%0d out_borrow", wid(i)), 64'(out_borrow[i]), 64'(m_borrow[i]));
          chk($sformatf("w%0d out_zero", wid(i)), 64'(out_zero[i]), 64'(m_zero[i]));
        end
        if (rst) begin
          last_acc[i] = -1;
          m_pending[i] = 0;
        end else begin
          if (in_valid[i] && in_ready[i]) begin
            dut_acc[i]++;
            if (last_acc[i] >= 0)
              chk($sformatf("w%0d interval>=W+2 (got %0d)", wid(i), cyc - last_acc[i]),
                  64'((cyc - last_acc[i]) >= wid(i) + 2), 64'd1);
            last_acc[i] = cyc;
          end
          if (out_valid[i] && out_ready[i]) dut_results[i]++;
          if (!m_pending[i] && in_valid[i]) begin
            m_pending[i] = 1;
            m_age[i]     = 0;
            m_diff[i]    = ref_diff(in_a[i], in_b[i], wid(i));
            m_borrow[i]  = ref_borrow(in_a[i], in_b[i], wid(i));
            m_zero[i]    = (m_diff[i] == 64'd0);
          end else if (m_pending[i]) begin
            if (m_age[i] >= wid(i) && out_ready[i]) begin
              m_pending[i] = 0;
              m_results[i]++;
            end else begin
              m_age[i]++;
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(input int i, input int limit);
    int t = 0;
    while (!in_ready[i] && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[i]) begin
      failures++;
      $display("FAIL w%0d wait in_ready timeout: got 0 expected 1", wid(i));
    end
  endtask

  task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b, input int hold,
                        input logic [63:0] e_diff, input bit e_borrow, input bit e_zero);
    int lat = 0;
    logic [63:0] held;
    wait_ready(i, 200);
    in_a[i] = a; in_b[i] = b; in_valid[i] = 1'b1; out_ready[i] = 1'b0;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    while (!out_valid[i] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("w%0d %0h-%0h latency", wid(i), a, b), 64'(lat), 64'(wid(i)));
    chk($sformatf("w%0d %0h-%0h diff", wid(i), a, b), out_diff[i], e_diff);
    chk($sformatf("w%0d %0h-%0h borrow", wid(i), a, b), 64'(out_borrow[i]), 64'(e_borrow));
    chk($sformatf("w%0d %0h-%0h zero", wid(i), a, b), 64'(out_zero[i]), 64'(e_zero));
    held = out_diff[i];
    for (int k = 0; k < hold; k++) begin
      in_valid[i] = k[0];
      in_a[i] = 64'($urandom); in_b[i] = 64'($urandom);
      @(posedge clk); #1;
      chk($sformatf("w%0d hold%0d diff", wid(i), k), out_diff[i], held);
      chk($sformatf("w%0d hold%0d in_ready", wid(i), k), 64'(in_ready[i]), 64'd0);
      chk($sformatf("w%0d hold%0d out_valid", wid(i), k), 64'(out_valid[i]), 64'd1);
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    chk($sformatf("w%0d post-handoff in_ready", wid(i)), 64'(in_ready[i]), 64'd1);
    chk($sformatf("w%0d post-handoff out_valid", wid(i)), 64'(out_valid[i]), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("w%0d reset in_ready", wid(i)), 64'(in_ready[i]), 64'd1);
      chk($sformatf("w%0d reset out_valid", wid(i)), 64'(out_valid[i]), 64'd0);
      chk($sformatf("w%0d reset out_diff", wid(i)), out_diff[i], 64'd0);
      chk($sformatf("w%0d reset out_borrow", wid(i)), 64'(out_borrow[i]), 64'd0);
      chk($sformatf("w%0d reset out_zero", wid(i)), 64'(out_zero[i]), 64'd0);
    end
    rst = 1'b0;

    // Hand-computed pins on the reference arithmetic itself.
    chk("model 5-3 w3", ref_diff(64'd5, 64'd3, 3), 64'd2);
    chk("model 3-5 w3", ref_diff(64'd3, 64'd5, 3), 64'd6);
    chk("model 3-5 w3 borrow", 64'(ref_borrow(64'd3, 64'd5, 3)), 64'd1);
    chk("model 0-1 w32", ref_diff(64'd0, 64'd1, 32), 64'hFFFF_FFFF);

    run_op(0, 64'd5, 64'd3, 0, 64'd2, 1'b0, 1'b0);
    run_op(0, 64'd3, 64'd5, 0, 64'd6, 1'b1, 1'b0);
    run_op(0, 64'd0, 64'd0, 0, 64'd0, 1'b0, 1'b1);
    run_op(0, 64'd7, 64'd0, 0, 64'd7, 1'b0, 1'b0);
    run_op(1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 64'd0, 1'b0, 1'b1);
    run_op(1, 64'd0, 64'd1, 5, 64'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(1, 64'h8000_0000, 64'h7FFF_FFFF, 0, 64'd1, 1'b0, 1'b0);

    // Abort mid-RUN: reset at RUN cycle 10, then a fresh 7-2.
    wait_ready(1, 200);
    in_a[1] = 64'h1234_5678; in_b[1] = 64'h0000_0042; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("w32 after abort in_ready", 64'(in_ready[1]), 64'd1);
    chk("w32 after abort out_valid", 64'(out_valid[1]), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("w32 no residual out_valid", 64'(out_valid[1]), 64'd0);
    run_op(1, 64'd7, 64'd2, 0, 64'd5, 1'b0, 1'b0);

    // Back-to-back random pairs on the 8-bit instance with random consumer backpressure.
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          in_a[2] = 64'($urandom_range(0, 255));
          in_b[2] = (n % 50 == 0) ? in_a[2] : 64'($urandom_range(0, 255));
          in_valid[2] = 1'b1;
          wait_ready(2, 100);
          @(posedge clk); #1;
        end
        in_valid[2] = 1'b0;
        for (int t = 0; t < 200 && !(in_ready[2] && !out_valid[2]); t++) begin
          @(posedge clk); #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready[2] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready[2] = 1'b0;
      end
    join

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("w%0d results handed off vs model", wid(i)), 64'(dut_results[i]), 64'(m_results[i]));
      chk($sformatf("w%0d accepts vs results", wid(i)), 64'(dut_acc[i] - (i == 1 ? 1 : 0)), 64'(dut_results[i]));
    end
    chk("w8 result count", 64'(dut_results[2]), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Iterative bit-serial subtractor for the ALU datapath. It computes `diff = in_a - in_b`, along with a borrow-out and a zero flag, using one bit slice per clock. This trades latency for area in narrow FPGA builds. It mirrors the ripple adders, but runs the carry/borrow chain in time instead of space, and it exchanges operands and results over valid/ready handshakes.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 2..64.
- `clk` input, 1 bit: rising-edge clock; the block's only clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operand pair `in_a`/`in_b` is valid.
- `in_ready` output, 1 bit: block can accept operands this cycle.
- `in_a` input, WIDTH bits: minuend, unsigned.
- `in_b` input, WIDTH bits: subtrahend, unsigned.
- `out_valid` output, 1 bit: result fields are valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_diff` output, WIDTH bits: `(in_a - in_b) mod 2^WIDTH`.
- `out_borrow` output, 1 bit: 1 when `in_a < in_b` (unsigned).
- `out_zero` output, 1 bit: 1 when `out_diff == 0`.

## Operation
FSM states and transitions:
- **IDLE**
  - `in_ready=1`.
  - On `in_valid` (accept):
    - Latch `in_a` and `in_b` into shift registers A and B.
    - Clear bit counter `cnt`, borrow register `br` and zero-accumulator `nz`.
    - Go to RUN.
- **RUN**
  - `in_ready=0`. Each cycle, the 1-bit slice computes `d = A[0]^B[0]^br` and `bo = (~A[0]&B[0]) | (~(A[0]^B[0])&br)`.
  - Shift `d` into the MSB of the result register, shifting right, so that after WIDTH shifts bit k lands in `out_diff[k]`.
  - Update `br <= bo`, `nz <= nz | d`, `cnt <= cnt+1`, and shift A and B right.
  - When `cnt == WIDTH-1`, go to DONE on the same edge.
- **DONE**
  - `out_valid=1` and `in_ready=0`.
  - `out_diff` = result register, `out_borrow` = `br`, `out_zero` = `~nz`.
  - When `out_ready=1`, go to IDLE. Operands are never accepted in the same cycle as result handoff.

Width and counter rules:
- `cnt` is `$clog2(WIDTH)` bits wide.
- The result register is WIDTH bits wide.
- Arithmetic is unsigned, and `out_diff` wraps mod 2^WIDTH.

Output and reset behaviour:
- `out_diff`, `out_borrow` and `out_zero` hold stable while `out_valid=1` and `out_ready=0`.
- Outside DONE, these outputs are don't-care but must not be X after reset.
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `out_diff=0`, `out_borrow=0`, `out_zero=0`, `cnt=0`.
- Reset mid-operation (in RUN or DONE) aborts the operation: the pending result is discarded and no `out_valid` pulse follows.
- `in_valid` while not in IDLE is ignored. The upstream block must hold its operands until `in_ready`.

## Timing
- Acceptance edge E0: `in_valid & in_ready` sampled high.
- RUN occupies WIDTH cycles (edges E1..E_WIDTH).
- `out_valid` rises in the cycle after edge E_WIDTH, so latency from the accept edge to `out_valid` is WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH for RUN, 1 for DONE and 1 for IDLE.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from any input.

## Structure
- Shared definitions go in `alu_definitions.v`:
  - `SSUB_IDLE=2'd0`, `SSUB_RUN=2'd1`, `SSUB_DONE=2'd2`.
  - `SSUB_STATE_W=2`.
- Sub-module `subtractor1bit`:
  - Ports `(diff, bout, a, b, bin)`, purely combinational.
  - It is the one-bit counterpart of `adder1bit` and is instantiated once for the serial slice.
- Top-level logic: FSM, counter, shift registers and output registers, each in its own always block.

## Test plan
- WIDTH=3, `in_a=5`, `in_b=3` → after 3 cycles: `out_valid=1`, `out_diff=2`, `out_borrow=0`, `out_zero=0`.
- WIDTH=3, `in_a=3`, `in_b=5` → `out_diff=6`, `out_borrow=1`, `out_zero=0`.
- WIDTH=32, `in_a=in_b=32'hDEADBEEF` → `out_diff=0`, `out_borrow=0`, `out_zero=1`, with `out_valid` exactly 32 cycles after the accept edge.
- WIDTH=32, `in_a=0`, `in_b=1`, `out_ready` held low 5 cycles:
  - Result is `32'hFFFFFFFF` with `out_borrow=1`, stable for all 5 cycles.
  - `in_ready` stays 0 during those cycles.
  - Second `in_valid` pulses are ignored.
  - After `out_ready`: one cycle to IDLE, then the next accept.
- Assert `rst` at RUN cycle 10 of 32 → next cycle: `in_ready=1`, `out_valid=0`. A fresh operation `7-2` then yields `out_diff=5` with no residual result.
- Back-to-back random pairs (≥1000, WIDTH=8, random `out_ready`) checked against a reference model. Checks:
  - No lost or duplicated results.
  - Every initiation interval ≥ WIDTH+2.
